// File: rtl/fpu_cmp_pkg.sv
// Shared types for the FPU compare engine: operand classes, FSM states,
// compare modes and {C3,C2,C0} condition-code encodings.
package fpu_cmp_pkg;

  typedef enum logic [2:0] {
    ZERO,
    DENORM,
    NORMAL,
    INF,
    QNAN,
    SNAN,
    UNSUPPORTED
  } cls_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CLASSIFY,
    ST_COMPARE,
    ST_DONE
  } state_e;

  localparam logic [1:0] CMP_FCOM  = 2'd0;
  localparam logic [1:0] CMP_FUCOM = 2'd1;
  localparam logic [1:0] CMP_FTST  = 2'd2;

  // Packed as {C3, C2, C0}
  localparam logic [2:0] CC_GT = 3'b000;
  localparam logic [2:0] CC_LT = 3'b001;
  localparam logic [2:0] CC_EQ = 3'b100;
  localparam logic [2:0] CC_UN = 3'b111;

  function automatic logic is_nan(input cls_e c);
    return (c == QNAN) || (c == SNAN);
  endfunction

endpackage

// File: rtl/fpu_cmp_classify.sv
// Combinational operand classifier. With FPU_CMP_UNNORMAL_EN defined and an
// explicit integer bit, unnormals and pseudo-NaN/INF classify as UNSUPPORTED.
module fpu_cmp_classify
  import fpu_cmp_pkg::*;
#(
  parameter int EXP_W        = 15,
  parameter int MAN_W        = 64,
  parameter int EXPLICIT_INT = 1
) (
  input  logic [EXP_W-1:0] exp,
  input  logic [MAN_W-1:0] man,
  output cls_e             cls
);

  // The explicit integer bit is not part of the fraction.
  localparam int FRAC_W = (EXPLICIT_INT != 0) ? MAN_W - 1 : MAN_W;

  logic [FRAC_W-1:0] frac;
  logic              exp_ones;
  logic              exp_zero;

  assign frac     = man[FRAC_W-1:0];
  assign exp_ones = &exp;
  assign exp_zero = ~|exp;

`ifndef FPU_CMP_UNNORMAL_EN
  logic unused_int_bit;
  assign unused_int_bit = man[MAN_W-1];
`endif

  always_comb begin
    cls = NORMAL;
    if (exp_ones) begin
      if (frac == '0)             cls = INF;
      else if (frac[FRAC_W-1])    cls = QNAN;
      else                        cls = SNAN;
    end else if (exp_zero) begin
      if (frac == '0)             cls = ZERO;
      else                        cls = DENORM;
    end
`ifdef FPU_CMP_UNNORMAL_EN
    if ((EXPLICIT_INT != 0) && !exp_zero && !man[MAN_W-1]) cls = UNSUPPORTED;
`endif
  end

endmodule

// File: rtl/fpu_compare_unit.sv
// Multi-cycle x87 compare engine (FCOM/FUCOM/FTST): IDLE -> CLASSIFY -> COMPARE -> DONE.
// Optional FPU_CMP_UNNORMAL_EN rejects unnormal / pseudo-special operands.
module fpu_compare_unit
  import fpu_cmp_pkg::*;
#(
  parameter int EXP_W        = 15,
  parameter int MAN_W        = 64,
  parameter int EXPLICIT_INT = 1,
  parameter int W            = 1 + EXP_W + MAN_W
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  input  logic [1:0]   mode,
  input  logic [W-1:0] operand_a,
  input  logic [W-1:0] operand_b,
  input  logic         flush,
  output logic         ready,
  output logic         done,
  output logic         cc_c3,
  output logic         cc_c2,
  output logic         cc_c0,
  output logic         invalid,
  output logic         denormal,
  output state_e       state_dbg
);

  // Handshake: start is taken only in a cycle where ready=1 and flush=0;
  // done is a single-cycle pulse and the result outputs hold until the next result.

  state_e       state, next_state;
  logic [1:0]   mode_q;
  logic [W-1:0] a_q, b_q;
  cls_e         cls_a_c, cls_b_c, cls_a, cls_b;
  logic [2:0]   cc_q, cc_c;
  logic         inv_q, inv_c, den_q, den_c;
  logic         accept;

  fpu_cmp_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W), .EXPLICIT_INT(EXPLICIT_INT)) u_cls_a (
    .exp (a_q[W-2:MAN_W]),
    .man (a_q[MAN_W-1:0]),
    .cls (cls_a_c)
  );

  fpu_cmp_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W), .EXPLICIT_INT(EXPLICIT_INT)) u_cls_b (
    .exp (b_q[W-2:MAN_W]),
    .man (b_q[MAN_W-1:0]),
    .cls (cls_b_c)
  );

  assign accept = (state == ST_IDLE) && start && !flush;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:     if (start && !flush) next_state = ST_CLASSIFY;
      ST_CLASSIFY: next_state = flush ? ST_IDLE : ST_COMPARE;
      ST_COMPARE:  next_state = flush ? ST_IDLE : ST_DONE;
      ST_DONE:     next_state = ST_IDLE;
      default:     next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    ready     = (state == ST_IDLE);
    done      = (state == ST_DONE);
    state_dbg = state;
  end

  // Compare on registered operands/classes; zero-class magnitudes count as 0.
  logic         sign_a, sign_b, unordered, nan_any, snan_any, unsup_any;
  logic [W-2:0] mag_a, mag_b;

  always_comb begin
    sign_a    = a_q[W-1];
    sign_b    = b_q[W-1];
    mag_a     = (cls_a == ZERO) ? '0 : a_q[W-2:0];
    mag_b     = (cls_b == ZERO) ? '0 : b_q[W-2:0];
    nan_any   = is_nan(cls_a) || is_nan(cls_b);
    snan_any  = (cls_a == SNAN) || (cls_b == SNAN);
    unsup_any = (cls_a == UNSUPPORTED) || (cls_b == UNSUPPORTED);
    unordered = nan_any || unsup_any;

    cc_c = CC_EQ;
    if (unordered)                           cc_c = CC_UN;
    else if (cls_a == ZERO && cls_b == ZERO) cc_c = CC_EQ;
    else if (sign_a != sign_b)               cc_c = sign_a ? CC_LT : CC_GT;
    else if (mag_a == mag_b)                 cc_c = CC_EQ;
    else if ((mag_a > mag_b) ^ sign_a)       cc_c = CC_GT;
    else                                     cc_c = CC_LT;

    inv_c = unsup_any || ((mode_q == CMP_FUCOM) ? snan_any : nan_any);
    den_c = ((cls_a == DENORM) || (cls_b == DENORM)) && !unordered;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mode_q <= CMP_FCOM;
      a_q    <= '0;
      b_q    <= '0;
      cls_a  <= ZERO;
      cls_b  <= ZERO;
      cc_q   <= CC_GT;
      inv_q  <= 1'b0;
      den_q  <= 1'b0;
    end else begin
      if (accept) begin
        mode_q <= mode;
        a_q    <= operand_a;
        b_q    <= (mode == CMP_FTST) ? '0 : operand_b;
      end
      if (state == ST_CLASSIFY) begin
        cls_a <= cls_a_c;
        cls_b <= cls_b_c;
      end
      if (state == ST_COMPARE && !flush) begin
        cc_q  <= cc_c;
        inv_q <= inv_c;
        den_q <= den_c;
      end
    end
  end

  assign cc_c3    = cc_q[2];
  assign cc_c2    = cc_q[1];
  assign cc_c0    = cc_q[0];
  assign invalid  = inv_q;
  assign denormal = den_q;

endmodule

// File: tb/tb_fpu_compare_unit.sv
// Self-checking bench for fpu_compare_unit (80-bit extended format); honours
// FPU_CMP_UNNORMAL_EN when the build defines it.
module tb_fpu_compare_unit;
  import fpu_cmp_pkg::*;

  localparam int W = 80;

  localparam logic [W-1:0] ONE    = 80'h3FFF_8000000000000000;
  localparam logic [W-1:0] HALF   = 80'h3FFE_8000000000000000;
  localparam logic [W-1:0] NHALF  = 80'hBFFE_8000000000000000;
  localparam logic [W-1:0] NONE   = 80'hBFFF_8000000000000000;
  localparam logic [W-1:0] NTWO   = 80'hC000_8000000000000000;
  localparam logic [W-1:0] PZERO  = 80'h0000_0000000000000000;
  localparam logic [W-1:0] NZERO  = 80'h8000_0000000000000000;
  localparam logic [W-1:0] QNAN_V = 80'h7FFF_C000000000000000;
  localparam logic [W-1:0] SNAN_V = 80'h7FFF_A000000000000000;
  localparam logic [W-1:0] PINF   = 80'h7FFF_8000000000000000;
  localparam logic [W-1:0] NINF   = 80'hFFFF_8000000000000000;
  localparam logic [W-1:0] DEN_V  = 80'h0000_0000000000000001;
  localparam logic [W-1:0] UNNORM = 80'h3FFF_0000000000000001;

  // Expected result packed as {C3, C2, C0, invalid, denormal}
  localparam logic [4:0] R_GT    = 5'b000_0_0;
  localparam logic [4:0] R_LT    = 5'b001_0_0;
  localparam logic [4:0] R_EQ    = 5'b100_0_0;
  localparam logic [4:0] R_UN    = 5'b111_0_0;
  localparam logic [4:0] R_UNI   = 5'b111_1_0;
  localparam logic [4:0] R_GTDEN = 5'b000_0_1;
`ifdef FPU_CMP_UNNORMAL_EN
  localparam logic [4:0] R_UNNORM = R_UNI;
`else
  localparam logic [4:0] R_UNNORM = R_LT;
`endif

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         start = 1'b0;
  logic         flush = 1'b0;
  logic [1:0]   mode = 2'd0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         ready, done, cc_c3, cc_c2, cc_c0, invalid, denormal;
  state_e       state_dbg;

  int tests = 0;
  int fails = 0;

  fpu_compare_unit #(.EXP_W(15), .MAN_W(64), .EXPLICIT_INT(1)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .mode      (mode),
    .operand_a (a),
    .operand_b (b),
    .flush     (flush),
    .ready     (ready),
    .done      (done),
    .cc_c3     (cc_c3),
    .cc_c2     (cc_c2),
    .cc_c0     (cc_c0),
    .invalid   (invalid),
    .denormal  (denormal),
    .state_dbg (state_dbg)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  // 0 zero, 1 denormal, 2 normal, 3 inf, 4 qnan, 5 snan, 6 unsupported
  function automatic int cls_of(input logic [W-1:0] x);
    logic [14:0] e;
    logic [62:0] f;
    e = x[78:64];
    f = x[62:0];
`ifdef FPU_CMP_UNNORMAL_EN
    if (e != 15'd0 && !x[63]) return 6;
`endif
    if (e == 15'h7FFF) begin
      if (f == 63'd0) return 3;
      return f[62] ? 4 : 5;
    end
    if (e == 15'd0) return (f == 63'd0) ? 0 : 1;
    return 2;
  endfunction

  // Order operands by their signed real-line position; NaN/unsupported is unordered.
  function automatic logic [4:0] model(input logic [1:0] m, input logic [W-1:0] x,
                                       input logic [W-1:0] y_in);
    logic [W-1:0]       y;
    int                 cx, cy;
    logic signed [80:0] kx, ky;
    logic               un, nan, snan, unsup, inv, den;
    logic [2:0]         cc;
    y  = (m == 2'd2) ? '0 : y_in;
    cx = cls_of(x);
    cy = cls_of(y);
    kx = '0;
    ky = '0;
    if (cx != 0) kx = {2'b00, x[78:0]};
    if (cy != 0) ky = {2'b00, y[78:0]};
    if (x[79]) kx = -kx;
    if (y[79]) ky = -ky;
    un    = (cx >= 4) || (cy >= 4);
    nan   = (cx == 4) || (cx == 5) || (cy == 4) || (cy == 5);
    snan  = (cx == 5) || (cy == 5);
    unsup = (cx == 6) || (cy == 6);
    if (un)            cc = 3'b111;
    else if (kx == ky) cc = 3'b100;
    else if (kx < ky)  cc = 3'b001;
    else               cc = 3'b000;
    inv = unsup || ((m == 2'd1) ? snan : nan);
    den = ((cx == 1) || (cy == 1)) && !un;
    return {cc, inv, den};
  endfunction

  // Cycle-level reference: cycles left until idle, plus held result.
  int         left;
  logic [4:0] held;
  logic [4:0] exp_q[$];

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      left <= 0;
      held <= '0;
      exp_q.delete();
    end else if (left == 0) begin
      if (start && !flush) begin
        left <= 3;
        exp_q.push_back(model(mode, a, b));
      end
    end else if (flush && left > 1) begin
      left <= 0;
      exp_q.delete();
    end else begin
      left <= left - 1;
      if (left == 2 && exp_q.size() > 0) held <= exp_q.pop_front();
    end
  end

  always @(negedge clk) begin
    check("ready", 32'(ready), 32'(left == 0));
    check("done", 32'(done), 32'(left == 1));
    check("result", 32'({cc_c3, cc_c2, cc_c0, invalid, denormal}), 32'(held));
  end

  task automatic run_cmp(input string name, input logic [1:0] m, input logic [W-1:0] va,
                         input logic [W-1:0] vb, input logic [4:0] expv);
    int k;
    @(negedge clk);
    mode  = m;
    a     = va;
    b     = vb;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = 0;
    while (!done && k < 8) begin
      @(negedge clk);
      k++;
    end
    check({name, "_latency"}, 32'(k), 32'd2);
    check(name, 32'({cc_c3, cc_c2, cc_c0, invalid, denormal}), 32'(expv));
    check({name, "_model"}, 32'(model(m, va, vb)), 32'(expv));
    @(negedge clk);
  endtask

  initial begin
    int seen;
    repeat (2) @(negedge clk);
    check("reset_ready", 32'(ready), 32'd1);
    check("reset_outputs", 32'({done, cc_c3, cc_c2, cc_c0, invalid, denormal}), 32'd0);
    check("reset_state", 32'(state_dbg), 32'(ST_IDLE));
    reset_n = 1'b1;
    @(negedge clk);

    run_cmp("fcom_eq",        CMP_FCOM,  ONE,    ONE,    R_EQ);
    run_cmp("fcom_lt",        CMP_FCOM,  HALF,   ONE,    R_LT);
    run_cmp("fcom_gt",        CMP_FCOM,  ONE,    HALF,   R_GT);
    run_cmp("fcom_pz_nz",     CMP_FCOM,  PZERO,  NZERO,  R_EQ);
    run_cmp("fcom_neg_gt",    CMP_FCOM,  NONE,   NTWO,   R_GT);
    run_cmp("fcom_sign_lt",   CMP_FCOM,  NHALF,  ONE,    R_LT);
    run_cmp("fcom_nz_pone",   CMP_FCOM,  NZERO,  ONE,    R_LT);
    run_cmp("fcom_inf_gt",    CMP_FCOM,  PINF,   ONE,    R_GT);
    run_cmp("fcom_ninf_eq",   CMP_FCOM,  NINF,   NINF,   R_EQ);
    run_cmp("fucom_qnan",     CMP_FUCOM, QNAN_V, ONE,    R_UN);
    run_cmp("fcom_qnan",      CMP_FCOM,  QNAN_V, ONE,    R_UNI);
    run_cmp("rsvd_qnan",      2'd3,      ONE,    QNAN_V, R_UNI);
    run_cmp("fucom_eq",       CMP_FUCOM, ONE,    ONE,    R_EQ);
    run_cmp("fucom_snan",     CMP_FUCOM, SNAN_V, ONE,    R_UNI);
    run_cmp("ftst_neg",       CMP_FTST,  NTWO,   SNAN_V, R_LT);
    run_cmp("ftst_denorm",    CMP_FTST,  DEN_V,  ONE,    R_GTDEN);
    run_cmp("fcom_den_un",    CMP_FCOM,  DEN_V,  QNAN_V, R_UNI);
    run_cmp("fucom_unnormal", CMP_FUCOM, UNNORM, ONE,    R_UNNORM);
    run_cmp("fcom_setup_lt",  CMP_FCOM,  HALF,   ONE,    R_LT);

    // Flush during CLASSIFY: no done, ready next cycle, previous result held.
    @(negedge clk);
    mode  = CMP_FCOM;
    a     = ONE;
    b     = HALF;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_ready", 32'(ready), 32'd1);
    check("flush_hold", 32'({cc_c3, cc_c2, cc_c0, invalid, denormal}), 32'(R_LT));
    seen = 0;
    repeat (4) begin
      @(negedge clk);
      if (done) seen = 1;
    end
    check("flush_no_done", 32'(seen), 32'd0);

    // Flush together with start in IDLE drops the start.
    start = 1'b1;
    flush = 1'b1;
    @(negedge clk);
    start = 1'b0;
    flush = 1'b0;
    check("flush_start_state", 32'(state_dbg), 32'(ST_IDLE));
    check("flush_start_ready", 32'(ready), 32'd1);

    // Async reset while in COMPARE after a nonzero result.
    run_cmp("fucom_snan_pre", CMP_FUCOM, SNAN_V, ONE, R_UNI);
    @(negedge clk);
    mode  = CMP_FCOM;
    a     = HALF;
    b     = ONE;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check("pre_reset_state", 32'(state_dbg), 32'(ST_COMPARE));
    #2 reset_n = 1'b0;
    #1;
    check("midreset_ready", 32'(ready), 32'd1);
    check("midreset_outputs", 32'({done, cc_c3, cc_c2, cc_c0, invalid, denormal}), 32'd0);
    check("midreset_state", 32'(state_dbg), 32'(ST_IDLE));
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    run_cmp("post_reset_eq", CMP_FCOM, NONE, NONE, R_EQ);

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fpu_compare_unit.md
Name: fpu_compare_unit

Overview:
Parametrised multi-cycle floating-point compare engine for the FPU_Core execute path. Serves FCOM, FUCOM and FTST.
- Accepts two operands of a configurable exponent/mantissa format.
- Classifies both operands, then compares them.
- Returns x87 condition codes C3/C2/C0 plus exception flags over a start/done handshake.
- Replaces the inline SUB-based compare in the arithmetic unit.

Parameters:
EXP_W, 15, exponent width
MAN_W, 64, significand width including integer bit when EXPLICIT_INT=1
EXPLICIT_INT, 1, 1 = explicit integer bit (80-bit extended); 0 = hidden bit (IEEE single/double)
W, 1+EXP_W+MAN_W, derived operand width; do not override

Ports:
clk  in  1  clock
reset_n  in  1  reset; asynchronous assert, active-low
start  in  1  request; accepted only when ready=1
mode  in  2  0=FCOM (signalling), 1=FUCOM (quiet), 2=FTST (compare a with +0), 3=reserved (treated as FCOM)
operand_a  in  W  ST(0)
operand_b  in  W  ST(i); ignored in FTST
flush  in  1  synchronous abort
ready  out  1  idle, can accept start
done  out  1  one-cycle result-valid pulse
cc_c3  out  1  equal/unordered
cc_c2  out  1  unordered
cc_c0  out  1  less/unordered
invalid  out  1  IE flag
denormal  out  1  DE flag

Behaviour:
- Reset values: ready=1; done, cc_c3, cc_c2, cc_c0, invalid and denormal all 0; state=IDLE.
- States and transitions:
  - IDLE → CLASSIFY on start&ready. Capture mode, operand_a, and operand_b (operand_b forced to +0 when mode=FTST).
  - CLASSIFY → COMPARE. Register a class per operand: ZERO, DENORM, NORMAL, INF, QNAN, SNAN.
  - COMPARE → DONE. Register the result.
  - DONE → IDLE. done=1 for exactly this cycle.
- Latency: start accepted at edge N; done high in cycle N+3; ready returns to 1 in cycle N+4.
- ready=0 in CLASSIFY, COMPARE and DONE. A start while ready=0 is ignored, with no queuing.
- Classification:
  - exp all-ones with fraction zero → INF.
  - exp all-ones with fraction nonzero → NaN. QNaN when the top fraction bit is set, otherwise SNaN.
  - Fraction means MAN_W-2:0 when EXPLICIT_INT=1, else the full field.
  - exp zero with fraction zero → ZERO; exp zero with fraction nonzero → DENORM.
- Result encoding:
  - Greater: C3,C2,C0 = 0,0,0.
  - Less: 0,0,1.
  - Equal: 1,0,0.
  - Unordered (either operand NaN): 1,1,1.
- Comparison rules:
  - +0 and -0 compare equal.
  - Same-sign operands: compare the magnitude {exp, mantissa} unsigned; reverse the result when both are negative.
  - Differing signs: the positive operand is greater.
  - INF is ordered normally.
- invalid:
  - FCOM/FTST: any NaN sets invalid.
  - FUCOM: only SNaN sets invalid.
- denormal: set when either operand is DENORM and not unordered.
- Output hold: cc and flags update in COMPARE→DONE and hold until the next accepted start. They are not cleared on return to IDLE.
- flush: in any non-IDLE state, go to IDLE next edge with no done pulse and outputs unchanged. A flush asserted together with start in IDLE wins, so the start is dropped.
- reset_n low mid-operation: immediately return all outputs to their reset values.

Optional Feature:
FPU_CMP_UNNORMAL_EN
- Defined, and EXPLICIT_INT=1: a nonzero, non-all-ones exponent with integer bit 0 (unnormal), or an all-ones exponent with integer bit 0 (pseudo-NaN/INF), is classified UNSUPPORTED. The result is unordered (1,1,1) and invalid=1 in every mode.
- Undefined: the integer bit is ignored for classification.

Decomposition:
- Package fpu_cmp_pkg holds:
  - the class enum (ZERO, DENORM, NORMAL, INF, QNAN, SNAN, UNSUPPORTED)
  - the mode constants (CMP_FCOM, CMP_FUCOM, CMP_FTST)
  - the cc encodings (CC_GT, CC_LT, CC_EQ, CC_UN)
- One sub-module, fpu_cmp_classify: combinational per-operand classifier parametrised by EXP_W/MAN_W/EXPLICIT_INT, instantiated twice.

Test Plan:
- FCOM, a=3FFF_8000000000000000, b=3FFF_8000000000000000 → done at N+3, C3/C2/C0=1/0/0, invalid=0.
- FCOM, a=3FFE_8000000000000000 (0.5), b=3FFF_8000000000000000 (1.0) → 0/0/1; swapped operands → 0/0/0; a=0000_0…0, b=8000_0…0 → 1/0/0.
- FUCOM, a=7FFF_C000000000000000 (QNaN), b=1.0 → 1/1/1 with invalid=0. Same operands under FCOM → invalid=1. FUCOM with a=7FFF_A000000000000000 (SNaN) → invalid=1.
- FTST, a=C000_8000000000000000 (-2.0) → 0/0/1. a=0000_0000000000000001 (denormal) → 0/0/0 with denormal=1.
- Start at N, flush in N+1 → no done pulse, ready=1 at N+2, cc still holds the previous result. reset_n low during COMPARE → all outputs 0 and ready=1 immediately.
- With FPU_CMP_UNNORMAL_EN: FUCOM a=3FFF_0000000000000001, b=1.0 → 1/1/1, invalid=1. Without the macro → 0/0/1.
